// File: rtl/traffic_scheduler.sv
// Per-frame sequencer for the AI vehicle slot pool: moves, retires and spawns
// vehicles once per frame and latches stable positions for the renderers.
module traffic_scheduler #(
    parameter int NUM_CARS      = 4,
    parameter int TRAFFIC_SPEED = 6,
    parameter int SPAWN_PERIOD  = 20,
    parameter int LANE_CLEAR    = 160,
    parameter int SPAWN_Y       = 0
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   frame_start,
    input  logic [9:0]             player_speed,
    input  logic [10:0]            random,
    output logic [NUM_CARS*11-1:0] car_x,
    output logic [NUM_CARS*11-1:0] car_y,
    output logic [NUM_CARS-1:0]    car_active,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
    localparam int TMR_W = $clog2(SPAWN_PERIOD + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UPDATE,
        S_SPAWN_CHECK,
        S_PROBE,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [2:0]          r_lane;
    logic [2:0]          r_probe_cnt;
    logic [TMR_W-1:0]    r_timer;
    logic [10:0]         r_x [NUM_CARS];
    logic [10:0]         r_y [NUM_CARS];
    logic [NUM_CARS-1:0] r_act;

    logic [10:0]         w_lane_x;
    logic                w_blocked;
    logic                w_any_free;
    logic [IDX_W-1:0]    w_free_idx;
    logic [10:0]         w_cur_y;
    logic [11:0]         w_y_next;
    logic                w_retire;
    logic                w_spawn;
    logic                w_enter_done;
    logic [10:0]         w_nx [NUM_CARS];
    logic [10:0]         w_ny [NUM_CARS];
    logic [NUM_CARS-1:0] w_nact;
    logic                w_unused;

    function automatic logic [10:0] f_lane_x(input logic [2:0] lane);
        return 11'd166 + 11'(lane) * 11'd33;
    endfunction

    assign w_unused = ^{random[10:3], player_speed[4:0]};

    // Slot motion, lane clearance, free-slot search and the post-spawn slot view.
    always_comb begin
        w_lane_x   = f_lane_x(r_lane);
        w_cur_y    = r_y[r_idx];
        // 12-bit two's complement: bit 11 set means the vehicle left the top edge
        w_y_next   = {1'b0, w_cur_y} + {7'b0, player_speed[9:5]} - 12'(TRAFFIC_SPEED);
        w_retire   = w_y_next[11] | (w_y_next >= 12'd480);
        w_blocked  = 1'b0;
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            w_blocked = w_blocked |
                        (r_act[i] & (r_x[i] == w_lane_x) & (r_y[i] < 11'(LANE_CLEAR)));
        end
        for (int i = NUM_CARS - 1; i >= 0; i--) begin
            w_any_free = w_any_free | ~r_act[i];
            w_free_idx = r_act[i] ? w_free_idx : IDX_W'(i);
        end
        w_spawn      = (r_state == S_PROBE) & ~w_blocked & w_any_free;
        w_enter_done = ((r_state == S_SPAWN_CHECK) & ~((r_timer == '0) & w_any_free)) |
                       ((r_state == S_PROBE) & (~w_blocked | (r_probe_cnt == 3'd7)));
        for (int i = 0; i < NUM_CARS; i++) begin
            w_nx[i]   = (w_spawn && (w_free_idx == IDX_W'(i))) ? w_lane_x : r_x[i];
            w_ny[i]   = (w_spawn && (w_free_idx == IDX_W'(i))) ? 11'(SPAWN_Y) : r_y[i];
            w_nact[i] = r_act[i] | (w_spawn && (w_free_idx == IDX_W'(i)));
        end
    end

    // Frame sequencer FSM with registered status and frame-latched slot outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_lane      <= 3'd0;
            r_probe_cnt <= 3'd0;
            r_timer     <= '0;
            r_act       <= '0;
            for (int i = 0; i < NUM_CARS; i++) begin
                r_x[i] <= 11'd0;
                r_y[i] <= 11'd0;
            end
            car_x      <= '0;
            car_y      <= '0;
            car_active <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_start && (r_state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_state <= S_UPDATE;
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        if (r_timer != '0) begin
                            r_timer <= r_timer - TMR_W'(1);
                        end
                    end
                end
                S_UPDATE: begin
                    if (r_act[r_idx]) begin
                        if (w_retire) begin
                            r_act[r_idx] <= 1'b0;
                            r_y[r_idx]   <= 11'd0;
                        end else begin
                            r_y[r_idx] <= w_y_next[10:0];
                        end
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_SPAWN_CHECK;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_SPAWN_CHECK: begin
                    if ((r_timer == '0) && w_any_free) begin
                        r_state     <= S_PROBE;
                        r_lane      <= random[2:0];
                        r_probe_cnt <= 3'd0;
                    end
                end
                S_PROBE: begin
                    if (w_spawn) begin
                        r_x[w_free_idx]   <= w_lane_x;
                        r_y[w_free_idx]   <= 11'(SPAWN_Y);
                        r_act[w_free_idx] <= 1'b1;
                        r_timer           <= TMR_W'(SPAWN_PERIOD);
                    end else begin
                        r_lane      <= r_lane + 3'd1;
                        r_probe_cnt <= r_probe_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            // Outputs change only together with the frame_done pulse
            if (w_enter_done) begin
                r_state    <= S_DONE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
                car_active <= w_nact;
                for (int i = 0; i < NUM_CARS; i++) begin
                    car_x[i*11 +: 11] <= w_nx[i];
                    car_y[i*11 +: 11] <= w_ny[i];
                end
            end
        end
    end

endmodule
